// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RISC-V datapath constants and register-file types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam int WORDSIZE = 64;
   localparam int REGCOUNT = 32;
   localparam int ADDRSIZE = $clog2(REGCOUNT);

   typedef logic [ADDRSIZE-1:0] reg_addr_t;
   typedef logic [WORDSIZE-1:0] word_t;

   localparam reg_addr_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : One combinational register-file read port with x0 zero-force and
//          optional write-through forwarding (macro REGFILE_BYPASS_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port
   import riscv_pkg::*;
#(
   parameter int WORDSIZE = riscv_pkg::WORDSIZE,
   parameter int REGCOUNT = riscv_pkg::REGCOUNT,
   parameter int ADDRSIZE = riscv_pkg::ADDRSIZE
) (
   input  logic [WORDSIZE-1:0] i_regs [REGCOUNT],
   input  logic [ADDRSIZE-1:0] i_rd_addr,
   input  logic                i_wr_fwd,
   input  logic [ADDRSIZE-1:0] i_wr_addr,
   input  logic [WORDSIZE-1:0] i_wr_data,
   output logic [WORDSIZE-1:0] o_rd_data
);

   logic [WORDSIZE-1:0] w_rd_data;

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      w_rd_data = '0;
      if (i_rd_addr != ADDRSIZE'(ZERO_REG)) begin
         if (i_wr_fwd && (i_wr_addr == i_rd_addr)) begin
            w_rd_data = i_wr_data;
         end else begin
            w_rd_data = i_regs[i_rd_addr];
         end
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{i_wr_fwd, i_wr_addr, i_wr_data};

   always_comb begin
      w_rd_data = '0;
      if (i_rd_addr != ADDRSIZE'(ZERO_REG)) begin
         w_rd_data = i_regs[i_rd_addr];
      end
   end
`endif

   assign o_rd_data = w_rd_data;

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : 32-entry integer register file, two combinational read ports, one
//          clocked write port, x0 hardwired to zero. Macro: REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
   import riscv_pkg::*;
#(
   parameter int WORDSIZE = riscv_pkg::WORDSIZE,
   parameter int REGCOUNT = riscv_pkg::REGCOUNT,
   parameter int ADDRSIZE = riscv_pkg::ADDRSIZE
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDRSIZE-1:0] rs1_addr,
   input  logic [ADDRSIZE-1:0] rs2_addr,
   output logic [WORDSIZE-1:0] rs1_data,
   output logic [WORDSIZE-1:0] rs2_data,
   input  logic                wr_en,
   input  logic [ADDRSIZE-1:0] wr_addr,
   input  logic [WORDSIZE-1:0] wr_data
);

   if (ADDRSIZE != $clog2(REGCOUNT)) begin : g_bad_addrsize
      $error("register_file: ADDRSIZE must equal log2(REGCOUNT)");
   end

   logic [WORDSIZE-1:0] r_regs [1:REGCOUNT-1];
   logic [WORDSIZE-1:0] w_regs [REGCOUNT];
   logic                w_wr_fwd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < REGCOUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != ADDRSIZE'(ZERO_REG))) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // x0 has no storage; it is a constant zero entry in the read view
   assign w_regs[0] = '0;

   for (genvar g = 1; g < REGCOUNT; g++) begin : g_read_view
      assign w_regs[g] = r_regs[g];
   end

   // Forwarding must not leak wr_data while the array is held in reset
   assign w_wr_fwd = wr_en & rst_n;

   regfile_read_port #(
      .WORDSIZE (WORDSIZE),
      .REGCOUNT (REGCOUNT),
      .ADDRSIZE (ADDRSIZE)
   ) u_rs1_port (
      .i_regs    (w_regs),
      .i_rd_addr (rs1_addr),
      .i_wr_fwd  (w_wr_fwd),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_rd_data (rs1_data)
   );

   regfile_read_port #(
      .WORDSIZE (WORDSIZE),
      .REGCOUNT (REGCOUNT),
      .ADDRSIZE (ADDRSIZE)
   ) u_rs2_port (
      .i_regs    (w_regs),
      .i_rd_addr (rs2_addr),
      .i_wr_fwd  (w_wr_fwd),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .o_rd_data (rs2_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module : tb_register_file
// Brief  : Self-checking bench for register_file against an array model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;

   logic [63:0] model [32];
   int          checks;
   int          fails;

   register_file dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural read value as seen right now, before the next edge
   function automatic logic [63:0] exp_rd(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 64'd0;
      if (BYPASS && wr_en && wr_addr == a) return wr_data;
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
   endtask

   // Issue one write at the next edge; model follows architectural rules
   task automatic do_write(input logic [4:0] a, input logic [63:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk);
      if (rst_n && a != 5'd0) model[a] = d;
      #1;
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_write(5'd3, 64'h1111);
      do_write(5'd17, 64'h2222);
      #2;
      rst_n = 1'b0;
      clear_model();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h5555;
      #1;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
         #0.1;
         checks++;
         if (rs1_data !== 64'd0) begin
            fails++; $display("FAIL reset_rs1 addr=%0d got=%h exp=0", i, rs1_data);
         end
         checks++;
         if (rs2_data !== 64'd0) begin
            fails++; $display("FAIL reset_rs2 addr=%0d got=%h exp=0", 31 - i, rs2_data);
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i); rs2_addr = 5'(i);
         #0.1;
         checks++;
         if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
            fails++;
            $display("FAIL post_reset addr=%0d got=%h/%h exp=0", i, rs1_data, rs2_data);
         end
      end
   endtask

   task automatic test_basic();
      do_write(5'd5, 64'h0000_0000_0000_aaaa);
      do_write(5'd6, 64'h0000_0000_0000_bbbb);
      rs1_addr = 5'd5; rs2_addr = 5'd6;
      #1;
      checks++;
      if (rs1_data !== 64'h0000_0000_0000_aaaa) begin
         fails++; $display("FAIL basic_x5 got=%h exp=%h", rs1_data, 64'haaaa);
      end
      checks++;
      if (rs2_data !== 64'h0000_0000_0000_bbbb) begin
         fails++; $display("FAIL basic_x6 got=%h exp=%h", rs2_data, 64'hbbbb);
      end
   endtask

   task automatic test_x0();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1;
      rs1_addr = 5'd0; rs2_addr = 5'd0;
      #1;
      checks++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
         fails++; $display("FAIL x0_same_cycle got=%h/%h exp=0", rs1_data, rs2_data);
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      #1;
      checks++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
         fails++; $display("FAIL x0_after_edge got=%h/%h exp=0", rs1_data, rs2_data);
      end
   endtask

   task automatic test_same_cycle();
      logic [63:0] exp_pre;
      exp_pre = BYPASS ? 64'h1234 : 64'd0;
      rs1_addr = 5'd7; rs2_addr = 5'd7;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234;
      #1;
      checks++;
      if (rs1_data !== exp_pre) begin
         fails++; $display("FAIL same_cycle_pre got=%h exp=%h", rs1_data, exp_pre);
      end
      checks++;
      if (rs2_data !== rs1_data) begin
         fails++; $display("FAIL same_cycle_ports got=%h exp=%h", rs2_data, exp_pre);
      end
      @(posedge clk);
      model[7] = 64'h1234;
      #1;
      wr_en = 1'b0;
      #1;
      checks++;
      if (rs1_data !== 64'h1234) begin
         fails++; $display("FAIL same_cycle_post got=%h exp=%h", rs1_data, 64'h1234);
      end
   endtask

   task automatic test_wr_en_gating();
      wr_en = 1'b0; wr_addr = 5'd9; wr_data = 64'hDEAD;
      rs1_addr = 5'd9;
      @(posedge clk); #1;
      checks++;
      if (rs1_data !== 64'd0) begin
         fails++; $display("FAIL wr_en_gating got=%h exp=0", rs1_data);
      end
   endtask

   task automatic test_back_to_back();
      do_write(5'd12, 64'h0123_4567_89ab_cdef);
      do_write(5'd12, 64'hfedc_ba98_7654_3210);
      rs1_addr = 5'd12; rs2_addr = 5'd12;
      #1;
      checks++;
      if (rs1_data !== 64'hfedc_ba98_7654_3210 || rs2_data !== rs1_data) begin
         fails++;
         $display("FAIL back_to_back got=%h/%h exp=%h", rs1_data, rs2_data, 64'hfedc_ba98_7654_3210);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         wr_en    = ($urandom_range(0, 3) != 0);
         wr_addr  = 5'($urandom_range(0, 31));
         wr_data  = {$urandom, $urandom};
         rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
         rs2_addr = 5'($urandom_range(0, 31));
         #1;
         checks++;
         if (rs1_data !== exp_rd(rs1_addr)) begin
            fails++;
            $display("FAIL random_rs1 n=%0d addr=%0d got=%h exp=%h", n, rs1_addr, rs1_data, exp_rd(rs1_addr));
         end
         checks++;
         if (rs2_data !== exp_rd(rs2_addr)) begin
            fails++;
            $display("FAIL random_rs2 n=%0d addr=%0d got=%h exp=%h", n, rs2_addr, rs2_data, exp_rd(rs2_addr));
         end
         @(posedge clk);
         if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
         #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic test_async_reset();
      do_write(5'd31, 64'hCAFE);
      rs2_addr = 5'd31;
      #1;
      checks++;
      if (rs2_data !== 64'hCAFE) begin
         fails++; $display("FAIL async_pre got=%h exp=%h", rs2_data, 64'hCAFE);
      end
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      checks++;
      if (rs2_data !== 64'd0) begin
         fails++; $display("FAIL async_reset got=%h exp=0", rs2_data);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_write(5'd31, 64'hBEEF);
      #1;
      checks++;
      if (rs2_data !== 64'hBEEF) begin
         fails++; $display("FAIL async_recover got=%h exp=%h", rs2_data, 64'hBEEF);
      end
   endtask

   initial begin
      checks = 0; fails = 0;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rs1_addr = '0; rs2_addr = '0;
      clear_model();
      #12;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_x0();
      test_same_cycle();
      test_wr_en_gating();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
